// File: rtl/reqrsp_rr_mux.sv
// reqrsp_rr_mux: round-robin N:1 reqrsp multiplexer; responses are routed back in issue order
// through a FIFO of granted indices.
package reqrsp_rr_mux_pkg;
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } q_t;
  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } p_t;
  typedef struct packed {
    q_t   q;
    logic q_valid;
    logic p_ready;
  } req_t;
  typedef struct packed {
    p_t   p;
    logic p_valid;
    logic q_ready;
  } rsp_t;
endpackage

module reqrsp_rr_mux #(
  parameter int  NrPorts      = 2,
  parameter int  MaxTrans     = 4,
  parameter type reqrsp_req_t = reqrsp_rr_mux_pkg::req_t,
  parameter type reqrsp_rsp_t = reqrsp_rr_mux_pkg::rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  reqrsp_req_t slv_req_i [NrPorts],
  output reqrsp_rsp_t slv_rsp_o [NrPorts],
  output reqrsp_req_t mst_req_o,
  input  reqrsp_rsp_t mst_rsp_i
);
  localparam int IdxW = reqrsp_rr_mux_pkg::idx_width(NrPorts);
  localparam int PtrW = reqrsp_rr_mux_pkg::idx_width(MaxTrans);
  localparam int CntW = reqrsp_rr_mux_pkg::idx_width(MaxTrans + 1);

  if (NrPorts < 2) begin : g_chk_ports
    $fatal(1, "reqrsp_rr_mux: NrPorts must be at least 2");
  end
  if (MaxTrans < 1) begin : g_chk_trans
    $fatal(1, "reqrsp_rr_mux: MaxTrans must be at least 1");
  end

  logic [IdxW-1:0] r_rr, r_lock_idx, w_arb_idx, w_idx, w_head;
  logic [IdxW-1:0] r_route [MaxTrans];
  logic [PtrW-1:0] r_wr, r_rd;
  logic [CntW-1:0] r_cnt;
  logic            r_lock, w_valid, w_full, w_empty, w_mst_q_valid, w_q_hs, w_p_ready, w_p_hs;

  // Scan downwards so the lowest offset from r_rr is the last, and winning, assignment.
  always_comb begin
    w_arb_idx = r_rr;
    for (int k = NrPorts - 1; k >= 0; k--)
      if (slv_req_i[IdxW'((int'(r_rr) + k) % NrPorts)].q_valid)
        w_arb_idx = IdxW'((int'(r_rr) + k) % NrPorts);
  end

  assign w_idx         = r_lock ? r_lock_idx : w_arb_idx;
  assign w_valid       = slv_req_i[w_idx].q_valid;
  assign w_full        = r_cnt == CntW'(MaxTrans);
  assign w_empty       = r_cnt == '0;
  assign w_mst_q_valid = w_valid & ~w_full;
  assign w_q_hs        = w_mst_q_valid & mst_rsp_i.q_ready;
  assign w_head        = r_route[r_rd];
  assign w_p_ready     = ~w_empty & slv_req_i[w_head].p_ready;
  assign w_p_hs        = w_p_ready & mst_rsp_i.p_valid;

  always_comb begin
    mst_req_o         = slv_req_i[w_idx];
    mst_req_o.q_valid = w_mst_q_valid;
    mst_req_o.p_ready = w_p_ready;
  end

  always_comb begin
    for (int i = 0; i < NrPorts; i++) begin
      slv_rsp_o[i]         = mst_rsp_i;
      slv_rsp_o[i].q_ready = w_q_hs && (w_idx == IdxW'(i));
      slv_rsp_o[i].p_valid = ~w_empty && mst_rsp_i.p_valid && (w_head == IdxW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
    end else begin
      r_lock     <= w_mst_q_valid & ~mst_rsp_i.q_ready;
      r_lock_idx <= w_idx;
      r_cnt      <= r_cnt + CntW'(w_q_hs) - CntW'(w_p_hs);
      if (w_q_hs) begin
        r_rr <= (w_idx == IdxW'(NrPorts - 1)) ? '0 : w_idx + 1'b1;
        r_wr <= (r_wr == PtrW'(MaxTrans - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_p_hs) r_rd <= (r_rd == PtrW'(MaxTrans - 1)) ? '0 : r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_q_hs) r_route[r_wr] <= w_idx;
  end

  a_no_rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mst_rsp_i.p_valid && w_empty));
  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_cnt <= CntW'(MaxTrans));
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_empty && w_p_hs));

  for (genvar i = 0; i < NrPorts; i++) begin : g_stable
    a_q_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      slv_req_i[i].q_valid && !slv_rsp_o[i].q_ready |=>
        slv_req_i[i].q_valid && slv_req_i[i].q == $past(slv_req_i[i].q));
  end
endmodule

// File: tb/tb_reqrsp_rr_mux.sv
// tb_reqrsp_rr_mux: randomized requesters and downstream against an in-flight transaction queue
// model; a separate monitor scoreboards responses per requester.
module tb_reqrsp_rr_mux;
  import reqrsp_rr_mux_pkg::*;
  localparam int N = 3;
  localparam int MT = 4;
  typedef struct {
    int          owner;
    logic [31:0] data;
  } tr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  req_t        slv_req [N];
  rsp_t        slv_rsp [N];
  req_t        mst_req;
  rsp_t        mst_rsp;
  int          n_chk = 0;
  int          n_err = 0;
  tr_t         dq [$];
  logic [31:0] exp_q [N][$];
  int          m_rr = 0;
  int          m_hold_idx = 0;
  int          seq = 0;
  bit          m_hold = 1'b0;
  bit          p_hold = 1'b0;
  bit          served [N];
  int          vprob, qprob, pprob, prprob;
  logic [N-1:0] vmask = '1;

  reqrsp_rr_mux #(
    .NrPorts(N), .MaxTrans(MT), .reqrsp_req_t(req_t), .reqrsp_rsp_t(rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req), .mst_rsp_i(mst_rsp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] resp_of(q_t q);
    return q.addr ^ {q.data[15:0], q.data[31:16]} ^ {31'b0, q.write};
  endfunction

  function automatic bit any_valid();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= slv_req[i].q_valid && !served[i];
    return a;
  endfunction

  task automatic chk_b(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (served[i]) begin
        slv_req[i].q_valid = 1'b0;
        served[i] = 1'b0;
      end
      if (!slv_req[i].q_valid && vmask[i] && $urandom_range(99) < vprob) begin
        slv_req[i].q_valid = 1'b1;
        slv_req[i].q.addr = {8'(i), 24'(seq)};
        slv_req[i].q.write = 1'($urandom);
        slv_req[i].q.data = $urandom;
        seq++;
      end
      slv_req[i].p_ready = $urandom_range(99) < prprob;
    end
    mst_rsp.q_ready = $urandom_range(99) < qprob;
    if (!p_hold) begin
      mst_rsp.p_valid = dq.size() > 0 && $urandom_range(99) < pprob;
      mst_rsp.p.data = (dq.size() > 0) ? dq[0].data : $urandom;
      mst_rsp.p.error = 1'b0;
    end
  endtask

  // Model: the grant goes to the first valid port at or after the last grant + 1, is held
  // once offered, and nothing is offered while MT transactions are in flight.
  task automatic check();
    int win = -1;
    int owner = -1;
    logic full, qv, qhs, pr, phs;
    logic [31:0] d;
    if (m_hold) win = m_hold_idx;
    else
      for (int k = 0; k < N; k++)
        if (win < 0 && slv_req[(m_rr + k) % N].q_valid) win = (m_rr + k) % N;
    full = dq.size() == MT;
    qv = win >= 0 && !full;
    qhs = qv && mst_rsp.q_ready;
    chk_b("mst_q_valid", mst_req.q_valid, qv);
    if (qv) chk_w("mst_q", 128'(mst_req.q), 128'(slv_req[win].q));
    for (int i = 0; i < N; i++)
      chk_b($sformatf("q_ready[%0d]", i), slv_rsp[i].q_ready, qhs && i == win);
    pr = 1'b0;
    if (dq.size() > 0) begin
      owner = dq[0].owner;
      pr = slv_req[owner].p_ready;
    end
    chk_b("mst_p_ready", mst_req.p_ready, pr);
    for (int i = 0; i < N; i++)
      chk_b($sformatf("p_valid[%0d]", i), slv_rsp[i].p_valid, mst_rsp.p_valid && i == owner);
    phs = mst_rsp.p_valid && pr;
    if (phs) void'(dq.pop_front());
    if (qhs) begin
      d = resp_of(slv_req[win].q);
      dq.push_back('{win, d});
      exp_q[win].push_back(d);
      m_rr = (win + 1) % N;
      served[win] = 1'b1;
    end
    m_hold = qv && !mst_rsp.q_ready;
    m_hold_idx = win;
    p_hold = mst_rsp.p_valid && !phs;
  endtask

  always @(negedge clk) begin
    if (rst_n)
      for (int i = 0; i < N; i++)
        if (slv_rsp[i].p_valid && slv_req[i].p_ready) begin
          if (exp_q[i].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL rsp_unexpected[%0d]: got data %0h, expected no response", i, slv_rsp[i].p.data);
          end else chk_w($sformatf("rsp_data[%0d]", i), 128'(slv_rsp[i].p.data), 128'(exp_q[i].pop_front()));
        end
  end

  task automatic cycle();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    check();
  endtask

  task automatic run(int v, int q, int p, int pr, int n);
    vprob = v;
    qprob = q;
    pprob = p;
    prprob = pr;
    repeat (n) cycle();
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      slv_req[i] = '0;
      slv_req[i].p_ready = 1'b1;
    end
    mst_rsp = '0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    dq.delete();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      served[i] = 1'b0;
    end
    m_rr = 0;
    m_hold = 1'b0;
    p_hold = 1'b0;
    @(negedge clk);
    check();
  endtask

  task automatic drain(string name);
    int c = 0;
    vprob = 0;
    qprob = 100;
    pprob = 100;
    prprob = 100;
    while ((dq.size() > 0 || any_valid() || p_hold) && c < 300) begin
      cycle();
      c++;
    end
    chk_b(name, dq.size() == 0 && !any_valid(), 1'b1);
  endtask

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      slv_req[i] = '0;
      served[i] = 1'b0;
    end
    mst_rsp = '0;
    do_reset(2);
    run(100, 100, 100, 100, 60);
    run(60, 40, 50, 70, 800);
    run(100, 100, 10, 100, 300);
    run(30, 80, 90, 30, 400);
    drain("drain_before_reset");
    vmask = 3'b011;
    run(100, 100, 0, 100, 1);
    vprob = 0;
    c = 0;
    while (any_valid() && c < 50) begin
      cycle();
      c++;
    end
    chk_b("issue_before_reset", any_valid(), 1'b0);
    vmask = '1;
    do_reset(1);
    run(0, 100, 0, 100, 3);
    run(100, 100, 100, 100, 40);
    run(50, 60, 60, 60, 200);
    drain("drain_final");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/reqrsp_rr_mux.md
REQRSP_RR_MUX -- requirements
Module: reqrsp_rr_mux

Interface
REQ-001 SHALL have parameter NrPorts, default 2: number of requester reqrsp ports; NrPorts >= 2, checked by an elaboration-time assertion.
REQ-002 SHALL have parameter MaxTrans, default 4: maximum in-flight transactions, equal to the route FIFO depth; MaxTrans >= 1.
REQ-003 SHALL have parameters reqrsp_req_t and reqrsp_rsp_t, default logic: the request and response structs of the codebase reqrsp typedef.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port slv_req_i, input, reqrsp_req_t[NrPorts]: requester q channels plus their p_ready.
REQ-007 SHALL have port slv_rsp_o, output, reqrsp_rsp_t[NrPorts]: per-requester q_ready and p channel.
REQ-008 SHALL have port mst_req_o, output, reqrsp_req_t: the shared downstream port, e.g. feeding the reqrsp-to-AXI converter.
REQ-009 SHALL have port mst_rsp_i, input, reqrsp_rsp_t: downstream q_ready and p channel.

Function
REQ-010 Index width SHALL be cf_math_pkg::idx_width(NrPorts); the count width SHALL be idx_width(MaxTrans+1).
REQ-011 Arbitration SHALL be round-robin: the requester with q_valid nearest at or above rr_q, wrapping modulo NrPorts, wins.
REQ-012 After a mst q handshake granted to port i, rr_q SHALL become (i+1) mod NrPorts; with no handshake, rr_q holds.
REQ-013 Request path SHALL be zero-latency: mst_req_o.q equals the winner's q, mst q_valid = winner valid & ~full, and winner q_ready = mst q_ready & ~full.
REQ-014 Non-winners SHALL see q_ready = 0.
REQ-015 Grant lock: once mst q_valid is asserted without q_ready, the granted index SHALL be held until handshake, keeping mst q stable per reqrsp rules, regardless of other requesters.
REQ-016 On every mst q handshake, the granted index SHALL be pushed into a route FIFO of depth MaxTrans.
REQ-017 On every mst p handshake, the head of the route FIFO SHALL be popped.
REQ-018 Full condition: count == MaxTrans; when full, mst q_valid SHALL be 0 and all slv q_ready SHALL be 0, even if a pop occurs in the same cycle (no bypass).
REQ-019 Response routing SHALL be zero-latency: slv_rsp_o[head].p = mst p, slv p_valid[head] = mst p_valid, mst p_ready = slv_req_i[head].p_ready; all other p_valid = 0.
REQ-020 Empty condition: when count == 0, mst p_ready SHALL be 0 and all slv p_valid SHALL be 0; an assertion SHALL flag mst p_valid while empty.
REQ-021 Simultaneous push and pop when not full SHALL leave count unchanged, with FIFO order preserved.
REQ-022 Pointers SHALL wrap modulo MaxTrans.
REQ-023 Responses SHALL be returned strictly in downstream issue order; no reordering.
REQ-024 Assertions SHALL check count never exceeds MaxTrans and never underflows.
REQ-025 Assertions SHALL check that a requester's q stays stable while its q_valid is high and its q_ready is low.

Reset
REQ-026 With rst_ni low at a clock edge, on the next cycle: FIFO empty (count 0, pointers 0), rr_q = 0, lock cleared.
REQ-027 During and after reset, outputs SHALL be derived from that state: mst q_valid follows inputs; slv p_valid all 0; mst p_ready 0.
REQ-028 Reset mid-operation SHALL discard all routing state; in-flight responses arriving after reset SHALL be treated per REQ-020.

Verification
REQ-029 Scenario: NrPorts=3; all ports q_valid constantly; mst q_ready=1 -> grants 0,1,2,0,1,2; responses routed to 0,1,2 in order.
REQ-030 Scenario: port 1 valid, mst q_ready=0 for 3 cycles, port 0 raises valid in cycle 2 -> grant stays 1 until its handshake; port 0 is granted next.
REQ-031 Scenario: MaxTrans=4; 4 handshakes with no responses -> 5th request sees q_ready=0 even with a p handshake in the same cycle; it is accepted the following cycle.
REQ-032 Scenario: port 2 issues, then port 0; responses D0 then D1 arrive -> port 2 receives D0, port 0 receives D1.
REQ-033 Scenario: slv p_ready of the head port held 0 for 2 cycles -> mst p_ready is 0 for those cycles; FIFO does not pop.
REQ-034 Scenario: rst_ni low for one cycle with 2 transactions in flight -> count 0 and rr_q 0 afterwards; a stray p_valid is not forwarded and fires the assertion.
